// File: rtl/reqack_arbiter.sv
// -----------------------------------------------------------------------------
// reqack_arbiter
//
// Purpose:
//   N:1 arbiter for a 4-phase request/acknowledge handshake. NREQ upstream
//   requesters share one downstream req/ack channel. The arbiter picks one
//   eligible requester, captures its data, and runs the full downstream
//   handshake. It then finishes the upstream handshake (return-to-zero)
//   before it arbitrates again. All outputs are registered. Everything is
//   synchronous to clk.
//
// Configuration macro:
//   REQACK_ARB_FIXED_PRIO_EN - when defined, the lowest eligible index always
//                              wins and no round-robin pointer is built.
//                              When undefined (default), arbitration is round
//                              robin: the search starts just above the last
//                              winner.
//
// Ports:
//   clk      in   1            rising-edge clock
//   rst_n    in   1            synchronous reset, active low
//   req      in   NREQ         per-requester request
//   ack      out  NREQ         per-requester acknowledge
//   i_dat    in   NREQ*DWIDTH  requester k data at [k*DWIDTH +: DWIDTH]
//   req_nxt  out  1            downstream request
//   ack_nxt  in   1            downstream acknowledge
//   o_dat    out  DWIDTH       downstream data, valid while req_nxt=1
//   grant    out  NREQ         one-hot channel owner, zero when idle
//   busy     out  1            high in any state other than IDLE
// -----------------------------------------------------------------------------
module reqack_arbiter #(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    output logic [NREQ-1:0]        ack,
    input  logic [NREQ*DWIDTH-1:0] i_dat,
    output logic                   req_nxt,
    input  logic                   ack_nxt,
    output logic [DWIDTH-1:0]      o_dat,
    output logic [NREQ-1:0]        grant,
    output logic                   busy
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RTZ  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              req_nxt_q, req_nxt_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic              busy_q, busy_d;
    logic [DWIDTH-1:0] o_dat_q;

    logic [NREQ-1:0]   elig;
    logic              win_found;
    logic [PTR_W-1:0]  win_idx;
    logic [DWIDTH-1:0] dat_arr [NREQ];

    // Unpack the flat data bus so the winner's word can be picked by index.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_dat_unpack
        assign dat_arr[gi] = i_dat[gi*DWIDTH +: DWIDTH];
    end

    // A requester that still sees its own ack high is finishing its
    // return-to-zero and must not be picked again yet.
    assign elig = req & ~ack_q;

`ifdef REQACK_ARB_FIXED_PRIO_EN
    // Scanning from the top down leaves the lowest eligible index as winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(i);
            end
        end
    end
`else
    logic [PTR_W-1:0] ptr_q, ptr_d;

    // Search starts one above the last winner and wraps. i = NREQ is the
    // last winner itself, so a lone requester can win again.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!win_found && elig[(int'(ptr_q) + i) % NREQ]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'((int'(ptr_q) + i) % NREQ);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == S_IDLE && win_found) begin
            ptr_d = win_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= PTR_W'(NREQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        req_nxt_d = req_nxt_q;
        ack_d     = ack_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d   = S_REQ;
                    req_nxt_d = 1'b1;
                    grant_d   = NREQ'(1) << win_idx;
                    busy_d    = 1'b1;
                end
            end
            S_REQ: begin
                if (ack_nxt) begin
                    state_d   = S_RTZ;
                    req_nxt_d = 1'b0;
                    ack_d     = grant_q;
                end
            end
            S_RTZ: begin
                // Both sides must have returned to zero, in either order.
                if (!ack_nxt && !(|(req & grant_q))) begin
                    state_d = S_IDLE;
                    ack_d   = '0;
                    grant_d = '0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d   = S_IDLE;
                req_nxt_d = 1'b0;
                ack_d     = '0;
                grant_d   = '0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            req_nxt_q <= 1'b0;
            ack_q     <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_nxt_q <= req_nxt_d;
            ack_q     <= ack_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
        end
    end

    // Data is captured only on a grant and then held, so upstream may change
    // its bus once acknowledged without disturbing the downstream word.
    always_ff @(posedge clk) begin
        if (rst_n && state_q == S_IDLE && win_found) begin
            o_dat_q <= dat_arr[win_idx];
        end
    end

    assign req_nxt = req_nxt_q;
    assign ack     = ack_q;
    assign grant   = grant_q;
    assign busy    = busy_q;
    assign o_dat   = o_dat_q;

    // Protocol checks and internal invariants (simulation only).
    a_req_held: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == S_REQ) |-> (|(req & grant_q)))
        else $error("requester dropped req while its request was outstanding");

    a_ack_nxt_idle: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == S_IDLE) |-> !ack_nxt)
        else $error("ack_nxt high while idle");

    a_ack_rtz: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(ack_q) && ((ack_q == '0) || (state_q == S_RTZ)))
        else $error("ack not one-hot-or-zero or high outside RTZ");

    a_grant_oh: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(grant_q))
        else $error("grant not one-hot-or-zero");

    a_req_nxt_req: assert property (@(posedge clk) disable iff (!rst_n)
        req_nxt_q |-> (state_q == S_REQ))
        else $error("req_nxt high outside REQ");

endmodule

// File: tb/tb_reqack_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reqack_arbiter
//
// Directed bench for reqack_arbiter (NREQ=4, DWIDTH=8). Inputs change and
// outputs are sampled on the falling clock edge; the DUT samples on the
// rising edge. Define REQACK_ARB_FIXED_PRIO_EN for the fixed-priority build.
// -----------------------------------------------------------------------------
module tb_reqack_arbiter;

    localparam int NREQ   = 4;
    localparam int DWIDTH = 8;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        ack;
    logic [NREQ*DWIDTH-1:0] i_dat;
    logic                   req_nxt;
    logic                   ack_nxt;
    logic [DWIDTH-1:0]      o_dat;
    logic [NREQ-1:0]        grant;
    logic                   busy;

    int n_cmp = 0;
    int n_err = 0;

    // Requester k presents dat_tab[k] in the default data pattern.
    logic [7:0] dat_tab [NREQ] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

    always #5 clk = ~clk;

    reqack_arbiter #(.NREQ(NREQ), .DWIDTH(DWIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .ack     (ack),
        .i_dat   (i_dat),
        .req_nxt (req_nxt),
        .ack_nxt (ack_nxt),
        .o_dat   (o_dat),
        .grant   (grant),
        .busy    (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req     = '0;
        ack_nxt = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_nxt", 32'(req_nxt), 32'd0);
        chk("rst_ack",     32'(ack),     32'd0);
        chk("rst_grant",   32'(grant),   32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        rst_n = 1'b1;
    endtask

    // Waits (bounded) for req_nxt, reports cycles waited, checks the grant.
    task automatic open_xact(input int w, input logic [7:0] d, output int n);
        n = 0;
        while (req_nxt !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_nxt_seen", 32'(req_nxt), 32'd1);
        chk("grant",        32'(grant),   32'd1 << w);
        chk("o_dat",        32'(o_dat),   32'(d));
        chk("busy_req",     32'(busy),    32'd1);
    endtask

    // Zero-delay downstream ack, then both sides return to zero together.
    task automatic close_xact(input int w, input bit rearm);
        ack_nxt = 1'b1;
        @(negedge clk);
        chk("ack_rise",    32'(ack),     32'd1 << w);
        chk("req_nxt_low", 32'(req_nxt), 32'd0);
        req[w]  = 1'b0;
        ack_nxt = 1'b0;
        @(negedge clk);
        chk("ack_fall",   32'(ack),   32'd0);
        chk("busy_idle",  32'(busy),  32'd0);
        chk("grant_idle", 32'(grant), 32'd0);
        if (rearm) req[w] = 1'b1;
        $display("xact: requester %0d data %h done", w, o_dat);
    endtask

    initial begin
        int n;
        int order [5];
        rst_n   = 1'b0;
        req     = '0;
        ack_nxt = 1'b0;
        i_dat   = 32'hD3C2B1A0;

        // 1. Single requester, latency.
        do_reset();
        req[2] = 1'b1;
        open_xact(2, 8'hC2, n);
        chk("t1_latency", 32'(n), 32'd1);
        close_xact(2, 1'b0);

        // 2. All requesting, re-raised after each handshake.
`ifdef REQACK_ARB_FIXED_PRIO_EN
        order = '{0, 0, 0, 0, 0};
`else
        order = '{0, 1, 2, 3, 0};
`endif
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            open_xact(order[k], dat_tab[order[k]], n);
            chk("t2_gap", 32'(n), 32'd1);
            close_xact(order[k], 1'b1);
        end
        req = '0;
        @(negedge clk);

        // 3. req[1] arrives while requester 3 owns the channel.
        req[3] = 1'b1;
        open_xact(3, 8'hD3, n);
        req[1]      = 1'b1;
        i_dat[15:8] = 8'h3C;
        close_xact(3, 1'b0);
        open_xact(1, 8'h3C, n);
        chk("t3_one_idle", 32'(n), 32'd1);
        close_xact(1, 1'b0);
        i_dat = 32'hD3C2B1A0;
        @(negedge clk);

        // 4a. req[0] falls 5 cycles before ack_nxt.
        req[0] = 1'b1;
        open_xact(0, 8'hA0, n);
        ack_nxt = 1'b1;
        @(negedge clk);
        chk("t4a_ack_rise", 32'(ack), 32'd1);
        req[0] = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("t4a_ack_hold", 32'(ack), 32'd1);
        end
        ack_nxt = 1'b0;
        @(negedge clk);
        chk("t4a_ack_fall", 32'(ack),  32'd0);
        chk("t4a_busy",     32'(busy), 32'd0);

        // 4b. ack_nxt falls 5 cycles before req[0].
        req[0] = 1'b1;
        open_xact(0, 8'hA0, n);
        ack_nxt = 1'b1;
        @(negedge clk);
        chk("t4b_ack_rise", 32'(ack), 32'd1);
        ack_nxt = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("t4b_ack_hold", 32'(ack), 32'd1);
        end
        req[0] = 1'b0;
        @(negedge clk);
        chk("t4b_ack_fall", 32'(ack),  32'd0);
        chk("t4b_busy",     32'(busy), 32'd0);
        $display("xact: rtz ordering both directions done");

        // 5. Reset while req_nxt is high; neighbours reset too.
        req[2] = 1'b1;
        open_xact(2, 8'hC2, n);
        rst_n   = 1'b0;
        req     = '0;
        ack_nxt = 1'b0;
        @(negedge clk);
        chk("t5_req_nxt", 32'(req_nxt), 32'd0);
        chk("t5_ack",     32'(ack),     32'd0);
        chk("t5_grant",   32'(grant),   32'd0);
        chk("t5_busy",    32'(busy),    32'd0);
        rst_n = 1'b1;
        req   = 4'b1111;
        open_xact(0, 8'hA0, n);
        close_xact(0, 1'b0);
        req = '0;
        @(negedge clk);

        // 6. Data held after ack even when the source bus changes.
        i_dat[15:8] = 8'hA5;
        req[1]      = 1'b1;
        open_xact(1, 8'hA5, n);
        ack_nxt = 1'b1;
        @(negedge clk);
        chk("t6_ack_rise", 32'(ack), 32'd2);
        i_dat[15:8] = 8'h5A;
        @(negedge clk);
        chk("t6_hold_rtz", 32'(o_dat), 32'hA5);
        req[1]  = 1'b0;
        ack_nxt = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t6_hold_idle", 32'(o_dat), 32'hA5);
        end
        req[1] = 1'b1;
        open_xact(1, 8'h5A, n);
        close_xact(1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
